pulse_replay_core: RTL and testbench

Counterpart of pulse_avg_core: the averager collapses N pulses into one, and this block expands one into N. It captures one pulse of samples into on-chip RAM, then replays that pulse num_rep times back-to-back as separate AXI-stream packets. It sits between axi_wrapper m_axis/s_axis ports inside a noc_block, on ce_clk, with pulse_size and num_rep taken from setting_regs.

---
 rtl/pulse_replay_core_pkg.sv | 20 ++
 rtl/pulse_replay_core_ram.sv | 27 ++
 rtl/pulse_replay_core.sv | 234 +++++++++++++++++++++++
 tb/tb_pulse_replay_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_replay_core_pkg.sv
// Shared settings-register addresses, state encoding and small helpers
// for the pulse capture/replay block.
package pulse_replay_core_pkg;

   localparam int SR_REPLAY_LENGTH     = 130;
   localparam int SR_REPLAY_NUM_REP    = 131;
   localparam int RB_REPLAY_MAX_LENGTH = 20;
   localparam int RB_REPLAY_COUNT      = 21;

   typedef enum logic {
      CAPTURE = 1'b0,
      PLAY    = 1'b1
   } state_e;

   // A repetition count of zero still plays the pulse once.
   function automatic logic [31:0] norm_reps(input logic [31:0] n);
      return (n == 32'd0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/pulse_replay_core_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// single registered read stage.
module pulse_replay_core_ram #(
   parameter int DEPTH  = 8192,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/pulse_replay_core.sv
// Captures one pulse of stream samples into RAM, then replays it num_rep
// times as back-to-back packets through a 2-entry output buffer.
module pulse_replay_core
   import pulse_replay_core_pkg::*;
#(
   parameter int MAX_PULSE_SIZE = 8192,
   parameter int WIDTH          = 32,
   parameter int USER_WIDTH     = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [31:0]           pulse_size,
   input  logic [31:0]           num_rep,
   output logic [31:0]           num_count,
   output logic                  busy,
   input  logic [WIDTH-1:0]      i_tdata,
   input  logic [USER_WIDTH-1:0] i_tuser,
   input  logic                  i_tvalid,
   input  logic                  i_tlast,
   output logic                  i_tready,
   output logic [WIDTH-1:0]      o_tdata,
   output logic [USER_WIDTH-1:0] o_tuser,
   output logic                  o_tvalid,
   output logic                  o_tlast,
   input  logic                  o_tready
);

   localparam int ADDR_W = $clog2(MAX_PULSE_SIZE);

   state_e                state_q, state_d;
   logic                  start_q, start_d;
   logic [ADDR_W-1:0]     len_m1_q, len_m1_d;
   logic [31:0]           reps_q, reps_d;
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     play_last_q, play_last_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  rd_last_q, rd_last_d;
   logic [31:0]           iss_rep_q, iss_rep_d;
   logic                  iss_done_q, iss_done_d;
   logic [31:0]           num_count_q, num_count_d;
   logic [USER_WIDTH-1:0] tuser_q, tuser_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [WIDTH-1:0]      slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
   logic                  slot0_last_q, slot0_last_d, slot1_last_q, slot1_last_d;

   logic                  in_hs, pop, push, rd_en, rd_last, latch;
   logic [31:0]           len_clamped;
   logic [ADDR_W-1:0]     len_m1_new;
   logic [WIDTH-1:0]      ram_rd_data;

   // Both stream ports use strict AXI valid/ready: a beat transfers on a
   // cycle with valid & ready both high; once valid is raised, it and the
   // beat contents hold until that transfer (only reset/clear may drop it).
   assign in_hs    = i_tvalid & i_tready;
   assign i_tready = (state_q == CAPTURE) & ~start_q;
   assign busy     = (state_q == PLAY);
   assign o_tvalid = (cnt_q != 2'd0);
   assign o_tdata  = o_tvalid ? slot0_data_q : '0;
   assign o_tlast  = o_tvalid & slot0_last_q;
   assign o_tuser  = tuser_q;
   assign num_count = num_count_q;

   assign pop     = o_tvalid & o_tready;
   assign push    = rd_vld_q;
   assign rd_last = (rd_ptr_q == play_last_q);
   // Issue a read only if the buffer can absorb it once it leaves the RAM.
   assign rd_en   = (state_q == PLAY) & ~iss_done_q &
                    (({1'b0, cnt_q} + {2'b0, rd_vld_q}) <= (3'd1 + {2'b0, pop}));

   always_comb begin
      len_clamped = pulse_size;
      if (pulse_size == 32'd0)                     len_clamped = 32'd1;
      else if (pulse_size > 32'(MAX_PULSE_SIZE))   len_clamped = 32'(MAX_PULSE_SIZE);
      len_m1_new = ADDR_W'(len_clamped - 32'd1);
   end

   pulse_replay_core_ram #(
      .DEPTH (MAX_PULSE_SIZE),
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .wr_en  (in_hs),
      .wr_addr(wr_ptr_q),
      .wr_data(i_tdata),
      .rd_en  (rd_en),
      .rd_addr(rd_ptr_q),
      .rd_data(ram_rd_data)
   );

   always_comb begin
      latch        = 1'b0;
      state_d      = state_q;
      start_d      = start_q;
      len_m1_d     = len_m1_q;
      reps_d       = reps_q;
      wr_ptr_d     = wr_ptr_q;
      play_last_d  = play_last_q;
      rd_ptr_d     = rd_ptr_q;
      rd_vld_d     = rd_en;
      rd_last_d    = rd_en & rd_last;
      iss_rep_d    = iss_rep_q;
      iss_done_d   = iss_done_q;
      num_count_d  = num_count_q;
      tuser_d      = tuser_q;
      cnt_d        = cnt_q;
      slot0_data_d = slot0_data_q;
      slot0_last_d = slot0_last_q;
      slot1_data_d = slot1_data_q;
      slot1_last_d = slot1_last_q;

      if (pop) begin
         if (cnt_q == 2'd2) begin
            slot0_data_d = slot1_data_q;
            slot0_last_d = slot1_last_q;
         end else if (push) begin
            slot0_data_d = ram_rd_data;
            slot0_last_d = rd_last_q;
         end
         cnt_d = cnt_q - 2'd1 + {1'b0, push};
      end else if (push) begin
         if (cnt_q == 2'd0) begin
            slot0_data_d = ram_rd_data;
            slot0_last_d = rd_last_q;
         end else begin
            slot1_data_d = ram_rd_data;
            slot1_last_d = rd_last_q;
         end
         cnt_d = cnt_q + 2'd1;
      end

      case (state_q)
         CAPTURE: begin
            if (start_q) begin
               latch   = 1'b1;
               start_d = 1'b0;
            end else if (in_hs) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               // num_count keeps the last pulse's total until new data arrives.
               if (wr_ptr_q == '0) begin
                  tuser_d     = i_tuser;
                  num_count_d = '0;
               end
               if ((wr_ptr_q == len_m1_q) || i_tlast) begin
                  play_last_d = wr_ptr_q;
                  wr_ptr_d    = '0;
                  rd_ptr_d    = '0;
                  iss_rep_d   = '0;
                  iss_done_d  = 1'b0;
                  state_d     = PLAY;
               end
            end
         end
         PLAY: begin
            if (rd_en) begin
               rd_ptr_d = rd_last ? '0 : rd_ptr_q + 1'b1;
               if (rd_last) begin
                  iss_rep_d = iss_rep_q + 32'd1;
                  if (iss_rep_q + 32'd1 == reps_q) iss_done_d = 1'b1;
               end
            end
            if (pop && o_tlast) begin
               num_count_d = num_count_q + 32'd1;
               if (num_count_q + 32'd1 == reps_q) begin
                  state_d = CAPTURE;
                  latch   = 1'b1;
               end
            end
         end
         default: state_d = CAPTURE;
      endcase

      if (clear) begin
         state_d     = CAPTURE;
         start_d     = 1'b0;
         latch       = 1'b1;
         num_count_d = '0;
         cnt_d       = 2'd0;
         rd_vld_d    = 1'b0;
         rd_last_d   = 1'b0;
      end

      if (latch) begin
         len_m1_d = len_m1_new;
         reps_d   = norm_reps(num_rep);
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CAPTURE;
         start_q      <= 1'b1;
         len_m1_q     <= '0;
         reps_q       <= 32'd1;
         wr_ptr_q     <= '0;
         play_last_q  <= '0;
         rd_ptr_q     <= '0;
         rd_vld_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         iss_rep_q    <= '0;
         iss_done_q   <= 1'b0;
         num_count_q  <= '0;
         tuser_q      <= '0;
         cnt_q        <= 2'd0;
         slot0_data_q <= '0;
         slot0_last_q <= 1'b0;
         slot1_data_q <= '0;
         slot1_last_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         len_m1_q     <= len_m1_d;
         reps_q       <= reps_d;
         wr_ptr_q     <= wr_ptr_d;
         play_last_q  <= play_last_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_vld_q     <= rd_vld_d;
         rd_last_q    <= rd_last_d;
         iss_rep_q    <= iss_rep_d;
         iss_done_q   <= iss_done_d;
         num_count_q  <= num_count_d;
         tuser_q      <= tuser_d;
         cnt_q        <= cnt_d;
         slot0_data_q <= slot0_data_d;
         slot0_last_q <= slot0_last_d;
         slot1_data_q <= slot1_data_d;
         slot1_last_q <= slot1_last_d;
      end
   end

endmodule

// File: tb/tb_pulse_replay_core.sv
// Directed vector bench for pulse_replay_core: capture, replay, clamping,
// back-pressure, clear and maximum-length pulses.
module tb_pulse_replay_core;

   localparam int MAX   = 8192;
   localparam int WIDTH = 32;
   localparam int UW    = 128;
   localparam int W     = WIDTH + 1;

   logic             clk = 1'b0;
   logic             reset, clear;
   logic [31:0]      pulse_size, num_rep, num_count;
   logic             busy;
   logic [WIDTH-1:0] i_tdata, o_tdata;
   logic [UW-1:0]    i_tuser, o_tuser;
   logic             i_tvalid, i_tlast, i_tready;
   logic             o_tvalid, o_tlast, o_tready;

   pulse_replay_core #(
      .MAX_PULSE_SIZE(MAX),
      .WIDTH         (WIDTH),
      .USER_WIDTH    (UW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .pulse_size(pulse_size),
      .num_rep   (num_rep),
      .num_count (num_count),
      .busy      (busy),
      .i_tdata   (i_tdata),
      .i_tuser   (i_tuser),
      .i_tvalid  (i_tvalid),
      .i_tlast   (i_tlast),
      .i_tready  (i_tready),
      .o_tdata   (o_tdata),
      .o_tuser   (o_tuser),
      .o_tvalid  (o_tvalid),
      .o_tlast   (o_tlast),
      .o_tready  (o_tready)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   int cap_cyc, extra_cyc, first_cyc, last_cyc;

   typedef struct {
      logic [31:0] ps;
      logic [31:0] nr;
      int          n_send;
      int          tlast_at;
      logic [31:0] base;
      int          ready_pct;
      int          exp_len;
      int          exp_reps;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int n, input logic [31:0] base, input int tlast_at,
                        input int cap_idx, input logic [UW-1:0] user);
      for (int i = 0; i < n; i++) begin
         int budget;
         bit ok;
         i_tdata  = base + 32'(i);
         i_tlast  = (i == tlast_at);
         i_tuser  = (i == 0) ? user : ~user;
         i_tvalid = 1'b1;
         ok = 1'b0;
         budget = 40000;
         while (!ok && budget > 0) begin
            @(negedge clk);
            budget--;
            if (i_tready) begin
               ok = 1'b1;
               if (i == cap_idx - 1) cap_cyc = cyc;
               if (i == cap_idx) extra_cyc = cyc;
            end
         end
         @(posedge clk);
         #1;
         if (!ok) begin
            check("in_timeout", 0, 1);
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
            return;
         end
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
   endtask

   task automatic collect(input int total, input int reps, input int pct, input logic [UW-1:0] user);
      int got, budget, bubbles, stall_err, play_err;
      bit stalled, seen;
      logic [W-1:0] held;
      got = 0; budget = total * 4 + 20000; bubbles = 0; stall_err = 0; play_err = 0;
      stalled = 1'b0; seen = 1'b0; held = '0;
      while (got < total && budget > 0) begin
         @(posedge clk);
         #1;
         o_tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
         @(negedge clk);
         budget--;
         if (stalled && (!o_tvalid || {o_tlast, o_tdata} !== held)) stall_err++;
         stalled = o_tvalid && !o_tready;
         held = {o_tlast, o_tdata};
         if (o_tvalid && !seen) begin
            seen = 1'b1;
            first_cyc = cyc;
         end
         if (seen && !o_tvalid) bubbles++;
         if ((busy || seen) && i_tready) play_err++;
         if (o_tvalid && o_tready) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("beat", {o_tlast, o_tdata}, e);
            check("tuser", o_tuser, user);
            got++;
            last_cyc = cyc;
         end
      end
      check("beats_out", got, total);
      @(negedge clk);
      check("num_count_end", num_count, reps);
      check("i_tready_after", i_tready, 1);
      check("busy_after", busy, 0);
      check("stable_stall", stall_err, 0);
      check("i_tready_play", play_err, 0);
      check("latency_le3", (first_cyc > cap_cyc) && (first_cyc - cap_cyc <= 3), 1);
      if (pct >= 100) check("no_bubbles", bubbles, 0);
   endtask

   task automatic run_vector(input vec_t v, input int idx);
      logic [UW-1:0] user;
      logic [W-1:0] e;
      user = {4{32'hC0DE_0000 + 32'(idx)}};
      exp_q.delete();
      for (int r = 0; r < v.exp_reps; r++)
         for (int i = 0; i < v.exp_len; i++) begin
            e = {(i == v.exp_len - 1), v.base + 32'(i)};
            exp_q.push_back(e);
         end
      pulse_size = v.ps;
      num_rep    = v.nr;
      o_tready   = 1'b0;
      clear      = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      cap_cyc = 0;
      extra_cyc = 0;
      fork
         drive(v.n_send, v.base, v.tlast_at, v.exp_len, user);
         collect(v.exp_len * v.exp_reps, v.exp_reps, v.ready_pct, user);
      join
      if (v.n_send > v.exp_len) check("extra_after_play", extra_cyc > last_cyc, 1);
   endtask

   task automatic clear_test();
      int hs, budget;
      vec_t v;
      hs = 0;
      budget = 200;
      pulse_size = 32'd4;
      num_rep    = 32'd5;
      o_tready   = 1'b0;
      clear      = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      fork
         drive(4, 32'd50, 3, 4, 128'h5);
         begin
            o_tready = 1'b1;
            while (hs < 3 && budget > 0) begin
               @(negedge clk);
               budget--;
               if (o_tvalid) hs++;
            end
         end
      join
      check("clr_pre_beats", hs, 3);
      @(posedge clk);
      #1;
      clear      = 1'b1;
      o_tready   = 1'b0;
      pulse_size = 32'd4;
      num_rep    = 32'd1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("clr_o_tvalid", o_tvalid, 0);
      check("clr_num_count", num_count, 0);
      check("clr_i_tready", i_tready, 1);
      check("clr_busy", busy, 0);
      v = '{32'd4, 32'd1, 4, 3, 32'd60, 100, 4, 1};
      run_vector(v, 9);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = '{32'd8,    32'd3, 8,    7,  32'd0,      100, 8,    3};
      vecs[1] = '{32'd16,   32'd2, 5,    4,  32'd10,     100, 5,    2};
      vecs[2] = '{32'd0,    32'd0, 1,    -1, 32'h77,     100, 1,    1};
      vecs[3] = '{32'd4,    32'd2, 4,    3,  32'd100,    50,  4,    2};
      vecs[4] = '{32'd1,    32'd3, 1,    -1, 32'd200,    100, 1,    3};
      vecs[5] = '{32'd3,    32'd2, 4,    -1, 32'd300,    70,  3,    2};
      vecs[6] = '{32'd9000, 32'd1, 8193, -1, 32'h1000,   100, 8192, 1};

      reset = 1'b1; clear = 1'b0; pulse_size = 32'd8; num_rep = 32'd1;
      i_tdata = '0; i_tuser = '0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_i_tready", i_tready, 0);
      check("rst_o_tvalid", o_tvalid, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_i_tready", i_tready, 0);
      check("post_rst_o_tvalid", o_tvalid, 0);
      check("post_rst_o_tlast", o_tlast, 0);
      check("post_rst_o_tdata", o_tdata, 0);
      check("post_rst_o_tuser", o_tuser, 0);
      check("post_rst_num_count", num_count, 0);
      check("post_rst_busy", busy, 0);
      @(negedge clk);
      check("rst_i_tready_2nd", i_tready, 1);

      for (int k = 0; k < 6; k++) run_vector(vecs[k], k);
      clear_test();
      run_vector(vecs[6], 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
